flmult_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready flow control.

---
 rtl/flmult_pipe.sv | 193 +++++++++++++++++++
 tb/tb_flmult_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flmult_pipe.sv
// Purpose: 3-stage pipelined floating-point multiplier (FTZ, RNE, canonical qNaN); optional flags via FLMULT_FLAGS_EN.
// Latency: 3 cycles from accept to out_valid; one result per cycle.
// Backpressure: all stages advance together when !out_valid | out_ready; in_ready is that same term.
module flmult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result
`ifdef FLMULT_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int ES_W = EXP_W + 2;       // biased exponent sum plus sign and headroom
  localparam int PW   = 2 * MAN_W + 2;   // full significand product width
  localparam logic signed [ES_W-1:0] BIAS = ES_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [ES_W-1:0] EMAX = ES_W'((1 << EXP_W) - 1);
  localparam logic signed [ES_W-1:0] ONE  = ES_W'(1);
  localparam logic signed [ES_W-1:0] ZERO = '0;

  typedef enum logic [1:0] {CL_NUM, CL_ZERO, CL_INF, CL_NAN} cls_t;

  logic advance;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  cls_t             cls_d;
  logic signed [ES_W-1:0] esum_d;

  logic                   s1_vld, s1_sign;
  cls_t                   s1_cls;
  logic signed [ES_W-1:0] s1_esum;
  logic [MAN_W:0]         s1_ma, s1_mb;

  logic                   s2_vld, s2_sign;
  cls_t                   s2_cls;
  logic signed [ES_W-1:0] s2_esum;
  logic [PW-1:0]          s2_prod;

  logic [MAN_W-1:0]       man_t, man_f;
  logic [MAN_W:0]         man_r;
  logic                   guard, sticky, rnd_inc, ovf, unf;
  logic signed [ES_W-1:0] exp_n, exp_f;
  logic [W-1:0]           res_d;

  logic                   s3_vld;
  logic [W-1:0]           s3_res;

  assign advance   = !s3_vld || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_vld;
  assign result    = s3_res;

  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  // Operand classification; exp==0 (zero or subnormal) is flushed to zero
  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    cls_d  = CL_NUM;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) cls_d = CL_NAN;
    else if (a_inf || b_inf)                                      cls_d = CL_INF;
    else if (a_zero || b_zero)                                    cls_d = CL_ZERO;
  end

  // Two extra bits keep the largest sum (2*(2^EXP_W-2) - bias + 2) and the most negative one representable
  assign esum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  // Stage 1: unpacked operands, sign, exponent sum and class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_cls  <= CL_NUM;
      s1_esum <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
    end else if (advance) begin
      s1_vld  <= in_valid;
      s1_sign <= a[W-1] ^ b[W-1];
      s1_cls  <= cls_d;
      s1_esum <= esum_d;
      s1_ma   <= {1'b1, fa};
      s1_mb   <= {1'b1, fb};
    end
  end

  // Stage 2: full significand product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_cls  <= CL_NUM;
      s2_esum <= '0;
      s2_prod <= '0;
    end else if (advance) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_esum <= s1_esum;
      s2_prod <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
    end
  end

  // Normalise, round to nearest even, detect range limits and select specials
  always_comb begin
    if (s2_prod[PW-1]) begin
      man_t  = s2_prod[PW-2 -: MAN_W];
      guard  = s2_prod[MAN_W];
      sticky = |s2_prod[MAN_W-1:0];
      exp_n  = s2_esum + ONE;
    end else begin
      man_t  = s2_prod[PW-3 -: MAN_W];
      guard  = s2_prod[MAN_W-1];
      sticky = |s2_prod[MAN_W-2:0];
      exp_n  = s2_esum;
    end
    rnd_inc = guard && (sticky || man_t[0]);
    man_r   = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd_inc};
    if (man_r[MAN_W]) begin
      man_f = '0;
      exp_f = exp_n + ONE;
    end else begin
      man_f = man_r[MAN_W-1:0];
      exp_f = exp_n;
    end
    ovf = (exp_f >= EMAX);
    unf = (exp_f <= ZERO);
    case (s2_cls)
      CL_NAN:  res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      CL_INF:  res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CL_ZERO: res_d = {s2_sign, {(W-1){1'b0}}};
      default: begin
        if (ovf)      res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf) res_d = {s2_sign, {(W-1){1'b0}}};
        else          res_d = {s2_sign, exp_f[EXP_W-1:0], man_f};
      end
    endcase
  end

  // Stage 3: packed result register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld <= 1'b0;
      s3_res <= '0;
    end else if (advance) begin
      s3_vld <= s2_vld;
      s3_res <= res_d;
    end
  end

`ifdef FLMULT_FLAGS_EN
  logic [3:0] flags_d;
  logic [3:0] s3_flags;

  // Exception flags {invalid, overflow, underflow, inexact}; specials other than NaN raise none
  always_comb begin
    flags_d = 4'b0000;
    case (s2_cls)
      CL_NAN:  flags_d = 4'b1000;
      CL_NUM:  flags_d = {1'b0, ovf, !ovf && unf, guard || sticky || ovf || unf};
      default: flags_d = 4'b0000;
    endcase
  end

  // Flags travel in step with the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       s3_flags <= 4'b0000;
    else if (advance) s3_flags <= flags_d;
  end

  assign flags = s3_flags;
`endif

endmodule

// File: tb/tb_flmult_pipe.sv
`timescale 1ns/1ps
module tb_flmult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
`ifdef FLMULT_FLAGS_EN
  logic [3:0]  flags, h_flags;
`endif

  flmult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef FLMULT_FLAGS_EN
    , .flags(flags)
`endif
  );

  flmult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result)
`ifdef FLMULT_FLAGS_EN
    , .flags(h_flags)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t q[$];
  exp_t hq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single precision vectors: a, b, expected result, expected {invalid,overflow,underflow,inexact}
  localparam int NV = 12;
  logic [31:0] va [NV] = '{32'h3F800000, 32'h3FC00000, 32'h3F800001, 32'h7F800000,
                           32'hFF800000, 32'h7F7FFFFF, 32'h00800000, 32'h80400000,
                           32'h40000000, 32'h3FC00000, 32'hC0000000, 32'hFFC00001};
  logic [31:0] vb [NV] = '{32'h3F800000, 32'h3F800001, 32'h3F800001, 32'h00000000,
                           32'h40000000, 32'h40000000, 32'h00800000, 32'h3F800000,
                           32'h40400000, 32'h3FC00000, 32'h40400000, 32'h3F800000};
  logic [31:0] vr [NV] = '{32'h3F800000, 32'h3FC00002, 32'h3F800002, 32'h7FC00000,
                           32'hFF800000, 32'h7F800000, 32'h00000000, 32'h80000000,
                           32'h40C00000, 32'h40100000, 32'hC0C00000, 32'h7FC00000};
  logic [3:0]  vf [NV] = '{4'h0, 4'h1, 4'h1, 4'h8, 4'h0, 4'h5, 4'h3, 4'h0,
                           4'h0, 4'h0, 4'h0, 4'h8};

  // Half precision vectors
  localparam int NH = 6;
  logic [15:0] ha [NH] = '{16'h3C00, 16'h7BFF, 16'h7C00, 16'h0400, 16'h3E00, 16'h8200};
  logic [15:0] hb [NH] = '{16'h3C00, 16'h4000, 16'h0000, 16'h0400, 16'h3C01, 16'h3C00};
  logic [15:0] hr [NH] = '{16'h3C00, 16'h7C00, 16'h7E00, 16'h0000, 16'h3E02, 16'h8000};
  logic [3:0]  hf [NH] = '{4'h0, 4'h5, 4'h8, 4'h3, 4'h1, 4'h0};

  // Single precision monitor: pops the scoreboard on each output transfer, checks hold under stall
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_flg;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_result", result, prev_res);
`ifdef FLMULT_FLAGS_EN
        check("stall_flags", {28'b0, flags}, {28'b0, prev_flg});
`endif
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_output", {31'b0, out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          check("result", result, e.res);
`ifdef FLMULT_FLAGS_EN
          check("flags", {28'b0, flags}, {28'b0, e.flg});
`endif
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_res   <= result;
`ifdef FLMULT_FLAGS_EN
      prev_flg   <= flags;
`else
      prev_flg   <= 4'b0;
`endif
    end
  end

  // Half precision monitor
  always @(negedge clk) begin : mon_h
    exp_t e;
    if (rst_n && h_out_valid && h_out_ready) begin
      if (hq.size() == 0) begin
        check("half_spurious_output", {31'b0, h_out_valid}, 32'd0);
      end else begin
        e = hq.pop_front();
        check("half_result", {16'b0, h_result}, e.res);
`ifdef FLMULT_FLAGS_EN
        check("half_flags", {28'b0, h_flags}, {28'b0, e.flg});
`endif
      end
    end
  end

  // Feed n vectors back-to-back from index first; optionally toggle out_ready 1,0,0,...
  task automatic run_stream(input string tag, input int first, input int n, input bit toggle);
    int   idx = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t e;
    @(posedge clk); #1;
    while ((idx < n || q.size() != 0) && cyc < 300) begin
      out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      in_valid  = (idx < n);
      if (idx < n) begin
        a = va[first + idx];
        b = vb[first + idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        e.res = vr[first + idx];
        e.flg = vf[first + idx];
        q.push_back(e);
        idx++;
        if (idx == n) acc_cyc = cyc + 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_drain"}, q.size(), 32'd0);
    check({tag, "_sent"}, idx, n);
    if (!toggle) check({tag, "_throughput"}, acc_cyc, n);
  endtask

  initial begin
    int   lat;
    int   w;
    exp_t e;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    h_in_valid  = 1'b0;
    h_out_ready = 1'b1;
    h_a         = '0;
    h_b         = '0;

    #12;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
`ifdef FLMULT_FLAGS_EN
    check("reset_flags", {28'b0, flags}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Single operation latency with out_ready held high
    a = va[0]; b = vb[0]; in_valid = 1'b1;
    @(negedge clk);
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    e.res = vr[0]; e.flg = vf[0];
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", lat, 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // Remaining directed vectors back-to-back, full throughput
    run_stream("directed", 1, NV - 1, 1'b0);

    // Eight items with out_ready stalling two cycles in three
    run_stream("stream", 0, 8, 1'b1);

    // Reset with three items in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a = va[8 + i]; b = vb[8 + i]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("inflight_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_idle", {31'b0, out_valid}, 32'd0);
    run_stream("post_reset", 8, 4, 1'b0);

    // Half precision instance
    @(posedge clk); #1;
    for (int i = 0; i < NH; i++) begin
      h_a = ha[i]; h_b = hb[i]; h_in_valid = 1'b1;
      e.res = {16'b0, hr[i]}; e.flg = hf[i];
      hq.push_back(e);
      @(posedge clk); #1;
    end
    h_in_valid = 1'b0;
    w = 0;
    while (hq.size() != 0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("half_drain", hq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
